bg_palette_ctrl: RTL and testbench

Programmable background palette controller for the VGA background layer. Holds sixteen 24-bit palette entries that reset to the fixed background colour table, and translates a 4-bit pixel index into registered 8-bit R/G/B for the colour mapper. A host write port updates entries, with each update deferred to vertical blank to avoid tearing. A frame-driven palette-cycling engine rotates a configurable entry range for animated scenery.

---
 rtl/bg_palette_ctrl.sv | 142 ++++++++++++++
 tb/tb_bg_palette_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bg_palette_ctrl.sv
// Background palette: sixteen 24-bit entries with registered lookup, host writes
// deferred to vertical blank, and a frame-driven rotation of an entry range.
//
// state | meaning
// IDLE  | no host write pending, wr_req accepted
// PEND  | write latched, waiting for a vblank cycle free of rotation
module bg_palette_ctrl #(
   parameter int CYC_LO     = 9,
   parameter int CYC_HI     = 11,
   parameter int CYC_FRAMES = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        vblank,
   input  logic        pix_valid,
   input  logic [3:0]  pix_index,
   output logic        rgb_valid,
   output logic [7:0]  red_bgdata,
   output logic [7:0]  green_bgdata,
   output logic [7:0]  blue_bgdata,
   input  logic        wr_req,
   input  logic [3:0]  wr_addr,
   input  logic [23:0] wr_data,
   output logic        wr_ack,
   output logic        busy,
   input  logic        cyc_en
);

   localparam int CW = $clog2(CYC_FRAMES) + 1;
   localparam logic [CW-1:0] FRM_LAST = CW'(CYC_FRAMES - 1);
   localparam logic [3:0]    LO_IX    = 4'(CYC_LO);
   localparam logic [3:0]    HI_IX    = 4'(CYC_HI);

   localparam logic [23:0] PAL_RST [16] = '{
      24'h57B8FA, 24'h010308, 24'hFFFFFF, 24'h002FA2,
      24'hCC8A5E, 24'h518425, 24'h426823, 24'h5B9C20,
      24'hCC8A5E, 24'h9E5636, 24'h91563B, 24'h6C3B37,
      24'hE1DFDC, 24'h94CE51, 24'hFFFFFF, 24'hFFFFFF
   };

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     wr_addr_q;
   logic [23:0]    wr_data_q;
   logic           wr_ack_q;
   logic           vblank_d_q;
   logic [CW-1:0]  frm_cnt_q, frm_cnt_d;
   logic [23:0]    pal_q [16];
   logic [23:0]    pal_d [16];
   logic           rgb_valid_q;
   logic [23:0]    rgb_q;

   logic           vb_rise;
   logic           rot_step;
   logic           commit;
   logic           latch_req;

   assign vb_rise  = vblank & ~vblank_d_q;
   assign rot_step = vb_rise & cyc_en & (frm_cnt_q == FRM_LAST);

   always_comb begin
      frm_cnt_d = frm_cnt_q;
      if (!cyc_en) begin
         frm_cnt_d = '0;
      end else if (vb_rise) begin
         frm_cnt_d = (frm_cnt_q == FRM_LAST) ? '0 : frm_cnt_q + 1'b1;
      end
   end

   // Rotation owns the cycle; a due commit waits for the next vblank cycle.
   always_comb begin
      state_d   = state_q;
      commit    = 1'b0;
      latch_req = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (wr_req) begin
               latch_req = 1'b1;
               state_d   = PEND;
            end
         end
         PEND: begin
            busy = 1'b1;
            if (vblank && !rot_step) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pal_d = pal_q;
      if (rot_step) begin
         for (int i = CYC_LO; i < CYC_HI; i++) begin
            pal_d[4'(i)] = pal_q[4'(i + 1)];
         end
         pal_d[HI_IX] = pal_q[LO_IX];
      end else if (commit) begin
         pal_d[wr_addr_q] = wr_data_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_ack_q    <= 1'b0;
         vblank_d_q  <= 1'b0;
         frm_cnt_q   <= '0;
         pal_q       <= PAL_RST;
         rgb_valid_q <= 1'b0;
         rgb_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ack_q    <= commit;
         vblank_d_q  <= vblank;
         frm_cnt_q   <= frm_cnt_d;
         pal_q       <= pal_d;
         rgb_valid_q <= pix_valid;
         rgb_q       <= pix_valid ? pal_q[pix_index] : 24'h000000;
         if (latch_req) begin
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
         end
      end
   end

   assign rgb_valid    = rgb_valid_q;
   assign red_bgdata   = rgb_q[23:16];
   assign green_bgdata = rgb_q[15:8];
   assign blue_bgdata  = rgb_q[7:0];
   assign wr_ack       = wr_ack_q;

endmodule

// File: tb/tb_bg_palette_ctrl.sv
// Scoreboard bench for bg_palette_ctrl: the driver queues the expected lookup
// response per cycle, a negedge monitor pops and compares.
module tb_bg_palette_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        vblank = 1'b0;
   logic        pix_valid = 1'b0;
   logic [3:0]  pix_index = '0;
   logic        rgb_valid;
   logic [7:0]  red_bgdata, green_bgdata, blue_bgdata;
   logic        wr_req = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [23:0] wr_data = '0;
   logic        wr_ack;
   logic        busy;
   logic        cyc_en = 1'b0;

   int n_chk = 0;
   int n_err = 0;
   int ack_cnt = 0;

   typedef struct packed {
      logic        v;
      logic [23:0] rgb;
   } exp_t;
   exp_t exp_q[$];

   bg_palette_ctrl #(.CYC_LO(9), .CYC_HI(11), .CYC_FRAMES(8)) dut (
      .Clk(Clk), .Reset(Reset), .vblank(vblank),
      .pix_valid(pix_valid), .pix_index(pix_index),
      .rgb_valid(rgb_valid), .red_bgdata(red_bgdata),
      .green_bgdata(green_bgdata), .blue_bgdata(blue_bgdata),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .busy(busy), .cyc_en(cyc_en)
   );

   always #5 Clk = ~Clk;

   // Monitor: one expected lookup response per clock edge driven by the bench.
   always @(negedge Clk) begin
      logic [23:0] act;
      exp_t e;
      act = {red_bgdata, green_bgdata, blue_bgdata};
      if (wr_ack === 1'b1) ack_cnt++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (rgb_valid !== e.v || act !== e.rgb) begin
            n_err++;
            $display("FAIL lookup: got valid=%b rgb=%06h, expected valid=%b rgb=%06h at %0t",
                     rgb_valid, act, e.v, e.rgb, $time);
         end
      end else if (rgb_valid === 1'b1) begin
         n_chk++;
         n_err++;
         $display("FAIL lookup_unexpected: got valid=1 rgb=%06h, expected no response at %0t",
                  act, $time);
      end
   end

   task automatic step(input bit pv, input logic [3:0] idx, input logic [23:0] exp_rgb);
      pix_valid = pv;
      pix_index = idx;
      @(posedge Clk);
      exp_q.push_back('{v: pv, rgb: (pv ? exp_rgb : 24'h000000)});
      #1;
   endtask

   task automatic idle();
      step(1'b0, 4'd0, 24'h000000);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic vb_pulse();
      vblank = 1'b1;
      idle();
      vblank = 1'b0;
      idle();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      idle();
      idle();
      Reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks0;

      do_reset();
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_ack", 32'(wr_ack), 32'd0);

      // Default table lookups, back to back.
      step(1'b1, 4'd0, 24'h57B8FA);
      step(1'b1, 4'd3, 24'h002FA2);
      step(1'b1, 4'd13, 24'h94CE51);
      step(1'b1, 4'd15, 24'hFFFFFF);
      idle();

      // Deferred write, with a second request ignored while pending.
      acks0 = ack_cnt;
      vblank = 1'b0;
      wr_req = 1'b1; wr_addr = 4'd2; wr_data = 24'h123456;
      idle();
      chk("wr_busy_t1", 32'(busy), 32'd1);
      wr_data = 24'h777777;
      idle();
      wr_req = 1'b0;
      step(1'b1, 4'd2, 24'hFFFFFF);
      step(1'b1, 4'd2, 24'hFFFFFF);
      chk("wr_busy_hold", 32'(busy), 32'd1);
      chk("wr_ack_hold", 32'(wr_ack), 32'd0);
      vblank = 1'b1;
      step(1'b1, 4'd2, 24'hFFFFFF);
      chk("wr_ack_pulse", 32'(wr_ack), 32'd1);
      chk("wr_busy_clear", 32'(busy), 32'd0);
      step(1'b1, 4'd2, 24'h123456);
      chk("wr_ack_one_cycle", 32'(wr_ack), 32'd0);
      vblank = 1'b0;
      idle();
      idle();
      chk("wr_ack_count", 32'(ack_cnt - acks0), 32'd1);

      // Cycling of entries 9..11 every 8 vblank rises.
      do_reset();
      cyc_en = 1'b1;
      for (int i = 0; i < 7; i++) vb_pulse();
      step(1'b1, 4'd9, 24'h9E5636);
      vb_pulse();
      step(1'b1, 4'd9, 24'h91563B);
      step(1'b1, 4'd10, 24'h6C3B37);
      step(1'b1, 4'd11, 24'h9E5636);
      step(1'b1, 4'd8, 24'hCC8A5E);
      for (int i = 0; i < 8; i++) vb_pulse();
      step(1'b1, 4'd9, 24'h6C3B37);
      step(1'b1, 4'd10, 24'h9E5636);
      step(1'b1, 4'd11, 24'h91563B);
      step(1'b1, 4'd12, 24'hE1DFDC);

      // Commit colliding with a rotation step slips by one cycle.
      do_reset();
      cyc_en = 1'b1;
      for (int i = 0; i < 7; i++) vb_pulse();
      wr_req = 1'b1; wr_addr = 4'd5; wr_data = 24'hABCDEF;
      idle();
      wr_req = 1'b0;
      chk("col_busy", 32'(busy), 32'd1);
      vblank = 1'b1;
      idle();
      chk("col_no_ack_rise", 32'(wr_ack), 32'd0);
      chk("col_busy_rise", 32'(busy), 32'd1);
      idle();
      chk("col_ack", 32'(wr_ack), 32'd1);
      chk("col_busy_clear", 32'(busy), 32'd0);
      vblank = 1'b0;
      step(1'b1, 4'd5, 24'hABCDEF);
      step(1'b1, 4'd9, 24'h91563B);
      step(1'b1, 4'd11, 24'h9E5636);
      cyc_en = 1'b0;

      // Reset while a write is pending discards it.
      idle();
      acks0 = ack_cnt;
      wr_req = 1'b1; wr_addr = 4'd4; wr_data = 24'h111111;
      idle();
      wr_req = 1'b0;
      chk("rst_pend_busy", 32'(busy), 32'd1);
      Reset = 1'b1;
      idle();
      Reset = 1'b0;
      chk("rst_pend_busy_clear", 32'(busy), 32'd0);
      vblank = 1'b1;
      idle();
      idle();
      vblank = 1'b0;
      chk("rst_pend_no_ack", 32'(ack_cnt - acks0), 32'd0);
      step(1'b1, 4'd4, 24'hCC8A5E);
      step(1'b1, 4'd5, 24'h518425);
      idle();
      idle();

      @(negedge Clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
